// File: rtl/nc_pair_encode_scheduler_if.sv
// Handshake/bus bundle for nc_pair_encode_scheduler.
//   in_valid/in_ready  per input port (port 2c = side a W/S, 2c+1 = side b E/N)
//   in_cmp             7-bit compare vector per port {U,D,N,S,E,W,IP}
//   out_valid/ready    per-channel grant handshake
//   out_coded/src/dirs registered grant payload
//   cnt_coded/plain    per-channel saturating grant counters
// master = upstream/allocator side, slave = scheduler side.
interface nc_pair_encode_scheduler_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic [2*NUM_CH-1:0]             in_valid;
  logic [2*NUM_CH-1:0][6:0]        in_cmp;
  logic [2*NUM_CH-1:0]             in_ready;
  logic [NUM_CH-1:0]               out_valid;
  logic [NUM_CH-1:0]               out_ready;
  logic [NUM_CH-1:0]               out_coded;
  logic [NUM_CH-1:0][1:0]          out_src;
  logic [NUM_CH-1:0][6:0]          out_dirs;
  logic [NUM_CH-1:0][CNT_W-1:0]    cnt_coded;
  logic [NUM_CH-1:0][CNT_W-1:0]    cnt_plain;

  modport master (
    output in_valid, in_cmp, out_ready,
    input  in_ready, out_valid, out_coded, out_src, out_dirs, cnt_coded, cnt_plain
  );
  modport slave (
    input  in_valid, in_cmp, out_ready,
    output in_ready, out_valid, out_coded, out_src, out_dirs, cnt_coded, cnt_plain
  );
endinterface

// File: rtl/nc_pair_encode_scheduler.sv
// XOR network-coding pair scheduler. NUM_CH independent channels, each pairing
// two opposite ports, holding a lone head packet up to HOLD_MAX cycles for its
// partner, then issuing one registered grant (coded pair or uncoded singles).
// Ports: clk, rst (sync, active high), bus (nc_pair_encode_scheduler_if.slave).

// One channel: FSM, rule evaluation, grant register and statistics.
module nc_pair_encode_ch #(
  parameter int         HOLD_MAX = 4,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] MODE     = 2'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  input  logic [1:0][6:0]  in_cmp,
  output logic [1:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_coded,
  output logic [1:0]       out_src,
  output logic [6:0]       out_dirs,
  output logic [CNT_W-1:0] cnt_coded,
  output logic [CNT_W-1:0] cnt_plain
);
  localparam logic [6:0] MX = 7'b0000110;
  localparam logic [6:0] MY = 7'b0011000;
  localparam logic [6:0] MZ = 7'b1100000;
  localparam logic [1:0] EMODE = (MODE == 2'd3) ? 2'd0 : MODE;
  // Coding off means there is nobody worth waiting for.
  localparam logic [7:0] HOLD_EFF = (EMODE == 2'd0) ? 8'd0 : 8'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, ISSUE2} state_t;
  typedef struct packed { logic sat; logic [6:0] dirs; } rule_t;
  typedef struct packed { logic coded; logic [1:0] src; logic [6:0] dirs; } gnt_t;

  function automatic logic xeq(input logic [6:0] v); return ~v[1] & ~v[2]; endfunction
  function automatic logic yeq(input logic [6:0] v); return ~v[3] & ~v[4]; endfunction
  function automatic logic zeq(input logic [6:0] v); return ~v[5] & ~v[6]; endfunction

  function automatic logic [6:0] ec(input logic [6:0] v);
    return yeq(v) ? (zeq(v) ? (v & MX) : (v & MZ)) : 7'd0;
  endfunction
  function automatic logic [6:0] ed(input logic [6:0] v);
    return zeq(v) ? (yeq(v) ? (v & MX) : (v & MY)) : 7'd0;
  endfunction

  function automatic rule_t rule(input logic [6:0] a, input logic [6:0] b);
    rule_t r;
    logic  same;
    r    = '0;
    same = (xeq(a) & xeq(b)) | (yeq(a) & yeq(b)) | (zeq(a) & zeq(b));
    if (a[0] | b[0]) begin
      r = '0;
    end else if (EMODE == 2'd1) begin
      if (((a[3] & b[3]) | (a[4] & b[4])) & zeq(a) & zeq(b))
        r = '{1'b1, a & MY};
      else if (((a[5] & b[5]) | (a[6] & b[6])) & yeq(a) & yeq(b))
        r = '{1'b1, a & MZ};
      else if (~same & ((~a[3] & ~b[3]) | (~a[4] & ~b[4])))
        r = '{1'b1, ((a | b) & MY) | ec(a) | ec(b)};
      else if (~same & ((~a[5] & ~b[5]) | (~a[6] & ~b[6])))
        r = '{1'b1, ((a | b) & MZ) | ed(a) | ed(b)};
    end else if (EMODE == 2'd2) begin
      if (((a[5] & b[5]) | (a[6] & b[6])) & xeq(a) & xeq(b))
        r = '{1'b1, a & MZ};
    end
    return r;
  endfunction

  state_t     state;
  logic [6:0] ha, hb;
  logic [1:0] hvalid;   // WAIT: which side is held; ISSUE: 2'b10 = b still to grant
  logic [7:0] tmr;
  gnt_t       gnt;

  logic [1:0] fire;
  logic [6:0] pa, pb;
  rule_t      r;

  // Ready comes from state only; the rst gate keeps ports closed during reset.
  always_comb begin
    in_ready = 2'b00;
    if (!rst) begin
      case (state)
        IDLE:    in_ready = 2'b11;
        WAIT:    in_ready = ~hvalid;
        default: in_ready = 2'b00;
      endcase
    end
  end

  assign fire = in_valid & in_ready;
  // In WAIT one side comes from the hold register, the other from the port.
  assign pa   = hvalid[0] ? ha : in_cmp[0];
  assign pb   = hvalid[1] ? hb : in_cmp[1];
  assign r    = rule(pa, pb);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ha        <= '0;
      hb        <= '0;
      hvalid    <= '0;
      tmr       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      cnt_coded <= '0;
      cnt_plain <= '0;
    end else begin
      if (out_valid & out_ready) begin
        if (gnt.coded) begin
          if (cnt_coded != '1) cnt_coded <= cnt_coded + 1'b1;
        end else begin
          if (cnt_plain != '1) cnt_plain <= cnt_plain + 1'b1;
        end
      end
      case (state)
        IDLE, WAIT: begin
          if ((hvalid | fire) == 2'b11) begin
            // Full pair: partner beats timer expiry in the same cycle.
            hb        <= pb;
            out_valid <= 1'b1;
            state     <= ISSUE;
            if (r.sat) begin
              gnt    <= '{1'b1, 2'b11, r.dirs};
              hvalid <= 2'b00;
            end else begin
              gnt    <= '{1'b0, 2'b01, pa};
              hvalid <= 2'b10;
            end
          end else if (state == IDLE && fire != 2'b00) begin
            if (fire[0]) ha <= in_cmp[0];
            if (fire[1]) hb <= in_cmp[1];
            if (HOLD_EFF == 8'd0) begin
              gnt       <= '{1'b0, fire, fire[0] ? in_cmp[0] : in_cmp[1]};
              out_valid <= 1'b1;
              hvalid    <= 2'b00;
              state     <= ISSUE;
            end else begin
              hvalid <= fire;
              tmr    <= HOLD_EFF - 8'd1;
              state  <= WAIT;
            end
          end else if (state == WAIT) begin
            if (tmr == 8'd0) begin
              gnt       <= '{1'b0, hvalid, hvalid[0] ? ha : hb};
              out_valid <= 1'b1;
              hvalid    <= 2'b00;
              state     <= ISSUE;
            end else begin
              tmr <= tmr - 8'd1;
            end
          end
        end
        ISSUE: begin
          if (out_ready) begin
            if (hvalid[1]) begin
              gnt    <= '{1'b0, 2'b10, hb};
              hvalid <= 2'b00;
              state  <= ISSUE2;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        ISSUE2: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_coded = gnt.coded;
  assign out_src   = gnt.src;
  assign out_dirs  = gnt.dirs;
endmodule

module nc_pair_encode_scheduler #(
  parameter int                  NUM_CH   = 2,
  parameter logic [2*NUM_CH-1:0] CH_MODE  = {2'd2, 2'd1},
  parameter int                  HOLD_MAX = 4,
  parameter int                  CNT_W    = 16
) (
  input logic                       clk,
  input logic                       rst,
  nc_pair_encode_scheduler_if.slave bus
);
  logic [2*NUM_CH-1:0]          in_ready;
  logic [NUM_CH-1:0]            out_valid, out_coded;
  logic [NUM_CH-1:0][1:0]       out_src;
  logic [NUM_CH-1:0][6:0]       out_dirs;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_coded, cnt_plain;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    nc_pair_encode_ch #(
      .HOLD_MAX (HOLD_MAX),
      .CNT_W    (CNT_W),
      .MODE     (CH_MODE[2*c +: 2])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid[2*c +: 2]),
      .in_cmp    (bus.in_cmp[2*c +: 2]),
      .in_ready  (in_ready[2*c +: 2]),
      .out_valid (out_valid[c]),
      .out_ready (bus.out_ready[c]),
      .out_coded (out_coded[c]),
      .out_src   (out_src[c]),
      .out_dirs  (out_dirs[c]),
      .cnt_coded (cnt_coded[c]),
      .cnt_plain (cnt_plain[c])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_coded = out_coded;
  assign bus.out_src   = out_src;
  assign bus.out_dirs  = out_dirs;
  assign bus.cnt_coded = cnt_coded;
  assign bus.cnt_plain = cnt_plain;
endmodule
